// File: rtl/adder_share_arbiter_if.sv
// rtl/adder_share_arbiter_if.sv - request/response bundle for the shared adder arbiter
interface adder_share_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int N_REQ = 3,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_sub;
    logic [N_REQ-1:0]       req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [WIDTH-1:0]       rsp_sum;
    logic                   rsp_carry;
    logic                   rsp_zero;

    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_zero
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_zero
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin sharing of one adder among N_REQ requesters
module adder_share_arbiter #(
    parameter int WIDTH = 16,
    parameter int N_REQ = 3,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    adder_share_arbiter_if.slave bus
);
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  scan_idx;
    logic [ID_W-1:0]  win_id;
    logic             win_found;
    logic             can_accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic [WIDTH:0]   sum_ext;

    // The result slot frees in the same cycle it is consumed.
    assign can_accept = !bus.rsp_valid || bus.rsp_ready;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_found && bus.req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
            scan_idx = (scan_idx == ID_W'(N_REQ - 1)) ? '0 : scan_idx + 1'b1;
        end
        if (reset || !can_accept) begin
            win_found = 1'b0;
        end
    end

    assign bus.req_ready = win_found ? (N_REQ'(1) << win_id) : '0;

    always_comb begin
        op_a   = '0;
        op_b   = '0;
        op_sub = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                op_a   = bus.req_a[i*WIDTH +: WIDTH];
                op_b   = bus.req_b[i*WIDTH +: WIDTH];
                op_sub = bus.req_sub[i];
            end
        end
    end

    // Subtract is A + ~B + 1; the injected 1 rides on the carry-in position.
    assign sum_ext = {1'b0, op_a} + {1'b0, (op_sub ? ~op_b : op_b)} + {{WIDTH{1'b0}}, op_sub};

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr           <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_sum   <= '0;
            bus.rsp_carry <= 1'b0;
            bus.rsp_zero  <= 1'b0;
        end else if (win_found) begin
            ptr           <= (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= win_id;
            bus.rsp_sum   <= sum_ext[WIDTH-1:0];
            bus.rsp_carry <= op_sub ? 1'b0 : sum_ext[WIDTH];
            bus.rsp_zero  <= (sum_ext[WIDTH-1:0] == '0);
        end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - scoreboard bench for adder_share_arbiter
module tb_adder_share_arbiter;
    localparam int W = 16;
    localparam int N = 3;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] sum;
        logic        carry;
        logic        zero;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;

    adder_share_arbiter_if #(.WIDTH(W), .N_REQ(N), .ID_W(2)) bus ();

    adder_share_arbiter #(.WIDTH(W), .N_REQ(N), .ID_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    rsp_t       sb[$];
    logic [15:0] a_arr[N];
    logic [15:0] b_arr[N];
    logic [N-1:0] sub_vec;

    int  m_ptr  = 0;
    bit  m_pend = 1'b0;
    int  last_g;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rsp_t model_op(input int id, input logic [15:0] a, input logic [15:0] b, input bit sub);
        rsp_t r;
        logic [16:0] full;
        full    = {1'b0, a} + {1'b0, b};
        r.id    = 2'(id);
        r.sum   = sub ? (a - b) : full[15:0];
        r.carry = sub ? 1'b0 : full[16];
        r.zero  = (r.sum == 16'h0000);
        return r;
    endfunction

    // One clock of stimulus; checks grant and rsp_valid against the model.
    task automatic step(input bit rst, input logic [N-1:0] v, input bit rdy);
        logic [N-1:0] exp_rdy;
        int g;
        int idx;
        @(posedge clk);
        #1;
        reset         = rst;
        bus.req_valid = v;
        bus.rsp_ready = rdy;
        bus.req_a     = {a_arr[2], a_arr[1], a_arr[0]};
        bus.req_b     = {b_arr[2], b_arr[1], b_arr[0]};
        bus.req_sub   = sub_vec;
        @(negedge clk);
        check("rsp_valid", 64'(bus.rsp_valid), 64'(m_pend));
        g = -1;
        if (!rst && (!m_pend || rdy)) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && v[2'(idx)]) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? N'(1 << g) : '0;
        check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        last_g = g;
        if (rst) begin
            m_ptr  = 0;
            m_pend = 1'b0;
            sb.delete();
        end else if (g >= 0) begin
            sb.push_back(model_op(g, a_arr[g], b_arr[g], sub_vec[g]));
            m_ptr  = (g + 1) % N;
            m_pend = 1'b1;
        end else if (rdy) begin
            m_pend = 1'b0;
        end
    endtask

    // Monitor: pops the scoreboard on each consumed result and checks hold stability.
    rsp_t prev_rsp;
    bit   prev_hold = 1'b0;
    always @(negedge clk) begin
        rsp_t cur;
        rsp_t exp;
        cur = '{bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_zero};
        if (prev_hold)
            check("hold_stable", 64'(cur), 64'(prev_rsp));
        if (!reset && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_rsp", 64'(1), 64'(0));
            end else begin
                exp = sb.pop_front();
                check("rsp_fields", 64'(cur), 64'(exp));
            end
        end
        prev_hold = (reset === 1'b0) && (bus.rsp_valid === 1'b1) && (bus.rsp_ready === 1'b0);
        prev_rsp  = cur;
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        sub_vec       = '0;
        reset         = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sub   = '0;
        @(posedge clk);

        // T1 reset with all requests asserted
        step(1'b1, 3'b111, 1'b0);
        step(1'b1, 3'b111, 1'b0);
        check("reset_fields", 64'({bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_zero}), 64'(0));
        step(1'b0, 3'b111, 1'b1);
        check("t1_first_grant", 64'(last_g), 64'(0));

        // T2 add with carry out
        a_arr[1] = 16'hFFFF; b_arr[1] = 16'h0001; sub_vec = 3'b000;
        step(1'b0, 3'b010, 1'b1);
        check("t2_grant", 64'(last_g), 64'(1));
        step(1'b0, 3'b000, 1'b1);
        check("t2_result", 64'({bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_zero}),
              64'({2'd1, 16'h0000, 1'b1, 1'b1}));

        // T3 subtract going negative
        a_arr[2] = 16'h0005; b_arr[2] = 16'h0007; sub_vec = 3'b100;
        step(1'b0, 3'b100, 1'b1);
        step(1'b0, 3'b000, 1'b1);
        check("t3_result", 64'({bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_zero}),
              64'({2'd2, 16'hFFFE, 1'b0, 1'b0}));

        // T4 full contention rotates 0,1,2,...
        sub_vec = 3'b010;
        for (int i = 0; i < 6; i++) begin
            a_arr[i % N] = 16'(i * 4099);
            b_arr[i % N] = 16'(i * 777 + 3);
            step(1'b0, 3'b111, 1'b1);
            check("t4_order", 64'(last_g), 64'(i % N));
        end

        // T5 backpressure then release
        for (int i = 0; i < 3; i++) step(1'b0, 3'b111, 1'b0);
        step(1'b0, 3'b111, 1'b1);
        check("t5_regrant", 64'(last_g), 64'(0));

        // T6 reset while a result is held
        step(1'b0, 3'b111, 1'b0);
        step(1'b1, 3'b111, 1'b0);
        step(1'b0, 3'b000, 1'b1);
        step(1'b0, 3'b111, 1'b1);
        check("t6_grant_after_reset", 64'(last_g), 64'(0));

        // Boundary: 0 - 0
        a_arr[1] = 16'h0000; b_arr[1] = 16'h0000; sub_vec = 3'b010;
        step(1'b0, 3'b010, 1'b1);
        step(1'b0, 3'b000, 1'b1);
        check("zero_minus_zero", 64'({bus.rsp_sum, bus.rsp_carry, bus.rsp_zero}),
              64'({16'h0000, 1'b0, 1'b1}));

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 5))
                    0:       a_arr[i] = 16'hFFFF;
                    1:       a_arr[i] = 16'h0000;
                    default: a_arr[i] = 16'($urandom);
                endcase
                b_arr[i] = ($urandom_range(0, 4) == 0) ? a_arr[i] : 16'($urandom);
            end
            sub_vec = 3'($urandom);
            step($urandom_range(0, 59) == 0,
                 ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom),
                 $urandom_range(0, 3) != 0);
        end

        step(1'b0, 3'b000, 1'b1);
        step(1'b0, 3'b000, 1'b1);
        check("drain", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
